// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serialises one byte per request into an 11-slot frame, one slot per clk:
//   start(0), parity, D7..D0 (MSB first), stop(1). The frame is bracketed by
//   one START cycle and one END cycle, both idle-high, so back-to-back frames
//   are separated by exactly two high cycles. A one-deep pending buffer lets a
//   second byte be queued while a frame is on the line.
//
// Parameters
//   PARITY_ODD  0: parity slot = ^data (even), 1: parity slot = ~^data (odd)
//
// Ports
//   clk        system clock, all state changes on posedge
//   tx_enable  synchronous active-high reset (abandons any frame in progress)
//   tx_start   send request, sampled every cycle (pulse or level)
//   tx_data    byte to send, sampled only when tx_start is accepted
//   tx_out     serial line, idles high
//   tx_busy    high while a frame is in START/SEND/END
//   tx_full    pending buffer occupied; further tx_start is ignored
//   tx_done    one-cycle pulse during the END cycle of each frame
module uart_transmitter #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       tx_enable,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_END
    } state_t;

    state_t      state;
    logic [10:0] frame;
    logic [3:0]  slot_cnt;
    logic [7:0]  pending;

    function automatic logic [10:0] make_frame(input logic [7:0] d);
        logic par;
        par = PARITY_ODD ? ~^d : ^d;
        return {1'b0, par, d, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (tx_enable) begin
            state    <= S_IDLE;
            frame    <= '1;
            slot_cnt <= '0;
            pending  <= '0;
            tx_out   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_full  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Queue a second byte while a frame is on the line. The END cycle
            // is excluded: there a request either starts the next frame
            // directly (buffer empty) or is ignored (buffer being consumed).
            if ((state == S_START || state == S_SEND) && tx_start && !tx_full) begin
                pending <= tx_data;
                tx_full <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_start) begin
                        frame   <= make_frame(tx_data);
                        state   <= S_START;
                        tx_busy <= 1'b1;
                    end
                end

                // Line stays high for this cycle; slot0 goes out at the edge.
                S_START: begin
                    tx_out   <= frame[10];
                    frame    <= {frame[9:0], 1'b1};
                    slot_cnt <= '0;
                    state    <= S_SEND;
                end

                // slot_cnt holds the index of the slot currently on the line.
                S_SEND: begin
                    if (slot_cnt == 4'd10) begin
                        tx_out  <= 1'b1;
                        tx_done <= 1'b1;
                        state   <= S_END;
                    end else begin
                        tx_out   <= frame[10];
                        frame    <= {frame[9:0], 1'b1};
                        slot_cnt <= slot_cnt + 4'd1;
                    end
                end

                S_END: begin
                    tx_out <= 1'b1;
                    if (tx_full) begin
                        frame   <= make_frame(pending);
                        tx_full <= 1'b0;
                        state   <= S_START;
                    end else if (tx_start) begin
                        frame <= make_frame(tx_data);
                        state <= S_START;
                    end else begin
                        state   <= S_IDLE;
                        tx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
